muldiv_sequencer: RTL

- Iterative RV32M multiply/divide controller that sits beside the execute stage.
- Accepts one M-type operation from ID/EX, runs a radix-2 shift-add multiply or restoring divide over XLEN cycles, then presents the result for one cycle.
- Drives busy/ready so the hazard unit can stall the pipeline (stall = busy || ready) and hold EX/MEM (EX/MEM enable = !busy).
- Writes the result into EX/MEM in place of the ALU result.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_datapath.sv | 33 +++
 rtl/muldiv_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  // M-extension func3 encodings
  localparam logic [2:0] F3Mul    = 3'b000;
  localparam logic [2:0] F3Mulh   = 3'b001;
  localparam logic [2:0] F3Mulhsu = 3'b010;
  localparam logic [2:0] F3Mulhu  = 3'b011;
  localparam logic [2:0] F3Div    = 3'b100;
  localparam logic [2:0] F3Divu   = 3'b101;
  localparam logic [2:0] F3Rem    = 3'b110;
  localparam logic [2:0] F3Remu   = 3'b111;

  // func7 value that marks an OP instruction as M-type
  localparam logic [6:0] Func7M = 7'b0000001;

  // Sequencer state encoding
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  // Datapath step selection
  localparam logic ModeMul = 1'b0;
  localparam logic ModeDiv = 1'b1;

endpackage

// File: rtl/muldiv_datapath.sv
// Single radix-2 step: shift-add multiply or restoring divide on a 2*XLEN accumulator.
// Multiply: acc = {partial_hi, multiplier_lo}; divide: acc = {remainder, dividend/quotient}.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              mode_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   operand_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] add_sum;
  logic [XLEN:0] rem_shift;
  logic [XLEN:0] diff;

  // One iteration of the selected algorithm
  always_comb begin
    add_sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    rem_shift = acc_i[2*XLEN-1:XLEN-1];
    diff      = rem_shift - {1'b0, operand_i};
    if (mode_i == ModeMul) begin
      // Carry-out of the add shifts into the top bit
      acc_o = {add_sum, acc_i[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
    end else begin
      acc_o = {rem_shift[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide controller beside the execute stage.
// Operands are latched as magnitudes; sign fix-up and result selection happen in FIX.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned EARLY_OUT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            ready,
  output logic [XLEN-1:0] result,
  output logic            wr,
  output logic [4:0]      dest
);

  localparam logic [5:0]      LastCnt = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] MinInt  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   op1_q, op1_d;
  logic [2:0]        func3_q, func3_d;
  logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic              dz_q, dz_d, ovf_q, ovf_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        dest_q, dest_d;

  logic              sgn1, sgn2, neg1, neg2, is_div, div_zero, sgn_ovf, early;
  logic [XLEN-1:0]   mag1, mag2, quo_s, rem_s, fix_val;
  logic [2*XLEN-1:0] prod;

  muldiv_datapath #(
    .XLEN(XLEN)
  ) u_datapath (
    .mode_i   (func3_q[2]),
    .acc_i    (acc_q),
    .operand_i(opnd_q),
    .acc_o    (acc_step)
  );

  // Decode signedness and special cases of the incoming operation
  always_comb begin
    sgn1     = (func3 != F3Mulhu) && (func3 != F3Divu) && (func3 != F3Remu);
    sgn2     = sgn1 && (func3 != F3Mulhsu);
    neg1     = sgn1 && op1[XLEN-1];
    neg2     = sgn2 && op2[XLEN-1];
    mag1     = neg1 ? -op1 : op1;
    mag2     = neg2 ? -op2 : op2;
    is_div   = func3[2];
    div_zero = is_div && (op2 == '0);
    sgn_ovf  = is_div && !func3[0] && (op1 == MinInt) && (op2 == '1);
    early    = (EARLY_OUT != 0) && (div_zero || sgn_ovf);
  end

  // Sign correction and high/low or quotient/remainder selection
  always_comb begin
    prod    = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo_s   = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s   = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    fix_val = '0;
    unique case (func3_q)
      F3Mul:                    fix_val = prod[XLEN-1:0];
      F3Mulh, F3Mulhsu, F3Mulhu: fix_val = prod[2*XLEN-1:XLEN];
      F3Div, F3Divu:            fix_val = dz_q ? '1 : (ovf_q ? MinInt : quo_s);
      F3Rem, F3Remu:            fix_val = dz_q ? op1_q : (ovf_q ? '0 : rem_s);
    endcase
  end

  // Next-state logic for the FSM, counter and operand registers
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    op1_d    = op1_q;
    func3_d  = func3_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    dest_d   = dest_q;
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          state_d  = early ? StFix : StCalc;
          cnt_d    = '0;
          acc_d    = {{XLEN{1'b0}}, mag1};
          opnd_d   = mag2;
          op1_d    = op1;
          func3_d  = func3;
          sign_a_d = neg1;
          sign_b_d = neg2;
          dz_d     = div_zero;
          ovf_d    = sgn_ovf;
          dest_d   = rd_in;
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LastCnt) state_d = StFix;
        end
      end
      StFix: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          result_d = fix_val;
          state_d  = StDone;
        end
      end
      StDone: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      op1_q    <= '0;
      func3_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      dest_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      op1_q    <= op1_d;
      func3_q  <= func3_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      dest_q   <= dest_d;
    end
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy   = (state_q == StCalc) || (state_q == StFix);
    ready  = (state_q == StDone);
    wr     = ready && (dest_q != 5'd0);
    result = result_q;
    dest   = dest_q;
  end

endmodule
